// File: rtl/idc_stream.sv
// idc_stream: streaming image display controller.
// Loads an N x N signed image plus NOP window opcodes, applies the opcodes with a
// 2x2 window (one per cycle), then streams an (N/2) x (N/2) zoom-in or zoom-out view
// over a ready/valid output.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   in_valid   input beat valid (N*N consecutive beats per frame)
//   in_data    signed pixel, raster order
//   op         opcode, sampled on the first NOP beats of a frame
//   out_valid  output beat valid
//   out_data   signed output pixel (0 when out_valid is low)
//   out_ready  downstream accepts the beat
//   op_err     (only with IDC_OPERR_EN) an illegal opcode 9..15 was executed
//
// Optional feature macro: IDC_OPERR_EN adds the op_err output.
module idc_stream #(
    parameter int unsigned DW  = 7,
    parameter int unsigned N   = 8,
    parameter int unsigned NOP = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] in_data,
    input  logic [3:0]           op,
    output logic                 out_valid,
    output logic signed [DW-1:0] out_data,
    input  logic                 out_ready
`ifdef IDC_OPERR_EN
    ,
    output logic                 op_err
`endif
);

    localparam int unsigned AW    = $clog2(N);
    localparam int unsigned HW    = AW - 1;
    localparam int unsigned IW    = 2 * AW;
    localparam int unsigned CW    = IW + 1;
    localparam int unsigned OW    = (NOP > 1) ? $clog2(NOP) : 1;
    localparam int unsigned SW    = DW + 2;
    localparam int unsigned NBEAT = (N / 2) * (N / 2);

    typedef enum logic [1:0] {StIdle, StLoad, StProc, StOut} state_e;

    state_e               state_q, state_d;
    logic signed [DW-1:0] pix_q [N*N];
    logic signed [DW-1:0] pix_d [N*N];
    logic [3:0]           op_q  [NOP];
    logic [3:0]           op_d  [NOP];
    logic [AW-1:0]        r_q, r_d, c_q, c_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 err_q, err_d;

    // Window addresses: with N a power of two, {row, col} is row*N + col.
    logic [IW-1:0] ia, ib, ic, id;
    assign ia = {r_q, c_q};
    assign ib = {r_q, c_q + AW'(1)};
    assign ic = {r_q + AW'(1), c_q};
    assign id = {r_q + AW'(1), c_q + AW'(1)};

    logic signed [DW-1:0] pa, pb, pc, pd;
    assign pa = pix_q[ia];
    assign pb = pix_q[ib];
    assign pc = pix_q[ic];
    assign pd = pix_q[id];

    logic signed [DW-1:0] mx_ab, mx_cd, mn_ab, mn_cd, mid0, mid1;
    assign mx_ab = (pa > pb) ? pa : pb;
    assign mx_cd = (pc > pd) ? pc : pd;
    assign mn_ab = (pa < pb) ? pa : pb;
    assign mn_cd = (pc < pd) ? pc : pd;
    assign mid0  = (mx_ab < mx_cd) ? mx_ab : mx_cd;
    assign mid1  = (mn_ab > mn_cd) ? mn_ab : mn_cd;

    logic signed [SW-1:0] sum_mid, sum_avg, adj_mid, adj_avg, sh_mid, sh_avg;
    logic signed [DW-1:0] mid_res, avg_res;
    assign sum_mid = $signed({{2{mid0[DW-1]}}, mid0}) + $signed({{2{mid1[DW-1]}}, mid1});
    assign sum_avg = $signed({{2{pa[DW-1]}}, pa}) + $signed({{2{pb[DW-1]}}, pb})
                   + $signed({{2{pc[DW-1]}}, pc}) + $signed({{2{pd[DW-1]}}, pd});
    // Bias negative sums before the arithmetic shift so division truncates toward zero.
    assign adj_mid = sum_mid + (sum_mid[SW-1] ? SW'(1) : SW'(0));
    assign adj_avg = sum_avg + (sum_avg[SW-1] ? SW'(3) : SW'(0));
    assign sh_mid  = adj_mid >>> 1;
    assign sh_avg  = adj_avg >>> 2;
    assign mid_res = sh_mid[DW-1:0];
    assign avg_res = sh_avg[DW-1:0];

    logic [3:0] op_cur;
    assign op_cur = op_q[cnt_q[OW-1:0]];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        c_d     = c_q;
        pix_d   = pix_q;
        op_d    = op_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    pix_d[0] = in_data;
                    op_d[0]  = op;
                    cnt_d    = CW'(1);
                    r_d      = AW'(N / 2 - 1);
                    c_d      = AW'(N / 2 - 1);
                    state_d  = StLoad;
                end
            end
            StLoad: begin
                if (in_valid) begin
                    pix_d[cnt_q[IW-1:0]] = in_data;
                    if (cnt_q < CW'(NOP)) op_d[cnt_q[OW-1:0]] = op;
                    if (cnt_q == CW'(N * N - 1)) begin
                        cnt_d   = '0;
                        state_d = StProc;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            StProc: begin
                // Cycles 0..NOP-1 execute opcodes; cycle NOP settles the final window.
                if (cnt_q == CW'(NOP)) begin
                    cnt_d   = '0;
                    state_d = StOut;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    case (op_cur)
                        4'd0: begin
                            pix_d[ia] = mid_res;
                            pix_d[ib] = mid_res;
                            pix_d[ic] = mid_res;
                            pix_d[id] = mid_res;
                        end
                        4'd1: begin
                            pix_d[ia] = avg_res;
                            pix_d[ib] = avg_res;
                            pix_d[ic] = avg_res;
                            pix_d[id] = avg_res;
                        end
                        4'd2: begin
                            pix_d[ia] = pb;
                            pix_d[ib] = pd;
                            pix_d[ic] = pa;
                            pix_d[id] = pc;
                        end
                        4'd3: begin
                            pix_d[ia] = pc;
                            pix_d[ib] = pa;
                            pix_d[ic] = pd;
                            pix_d[id] = pb;
                        end
                        4'd4: begin
                            pix_d[ia] = -pa;
                            pix_d[ib] = -pb;
                            pix_d[ic] = -pc;
                            pix_d[id] = -pd;
                        end
                        4'd5: if (r_q != '0) r_d = r_q - AW'(1);
                        4'd6: if (c_q != '0) c_d = c_q - AW'(1);
                        4'd7: if (r_q != AW'(N - 2)) r_d = r_q + AW'(1);
                        4'd8: if (c_q != AW'(N - 2)) c_d = c_q + AW'(1);
                        default: err_d = 1'b1;
                    endcase
                end
            end
            StOut: begin
                if (out_ready) begin
                    if (cnt_q == CW'(NBEAT - 1)) begin
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            r_q     <= AW'(N / 2 - 1);
            c_q     <= AW'(N / 2 - 1);
            err_q   <= 1'b0;
            for (int i = 0; i < N * N; i++) pix_q[i] <= '0;
            for (int i = 0; i < NOP; i++) op_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            c_q     <= c_d;
            err_q   <= err_d;
            pix_q   <= pix_d;
            op_q    <= op_d;
        end
    end

    // Output addressing: beat index splits into (row, col) within the (N/2)^2 view.
    logic          zoom_in;
    logic [HW-1:0] jr, jc;
    logic [AW-1:0] orow, ocol;
    assign zoom_in = (r_q < AW'(N / 2)) && (c_q < AW'(N / 2));
    assign jr      = cnt_q[2*HW-1:HW];
    assign jc      = cnt_q[HW-1:0];
    assign orow    = zoom_in ? (r_q + AW'(1) + AW'(jr)) : {jr, 1'b0};
    assign ocol    = zoom_in ? (c_q + AW'(1) + AW'(jc)) : {jc, 1'b0};

    assign out_valid = (state_q == StOut);
    assign out_data  = out_valid ? pix_q[{orow, ocol}] : '0;

`ifdef IDC_OPERR_EN
    assign op_err = out_valid & err_q;
`endif

endmodule

// File: tb/tb_idc_stream.sv
// Directed bench for idc_stream (N=8, DW=7, NOP=15, image pixel k = k-32).
module tb_idc_stream;

    localparam int DW  = 7;
    localparam int N   = 8;
    localparam int NOP = 15;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic signed [DW-1:0] in_data;
    logic [3:0]           op;
    logic                 out_valid;
    logic signed [DW-1:0] out_data;
    logic                 out_ready;
`ifdef IDC_OPERR_EN
    logic                 op_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;
    logic seen;
    logic signed [31:0] got [16];
    int exp1 [16] = '{1, 2, 3, 4, 9, 10, 11, 12, 17, 18, 19, 20, 25, 26, 27, 28};
    int exp2 [16] = '{-32, -30, -28, -26, -16, -14, -12, -10, 0, 2, 4, 6, 16, 18, 20, 22};

    idc_stream #(.DW(DW), .N(N), .NOP(NOP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .op        (op),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef IDC_OPERR_EN
        ,
        .op_err    (op_err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [3:0] op0, input logic [3:0] oprest);
        for (int k = 0; k < N * N; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = DW'(k - 32);
            op       = (k == 0) ? op0 : ((k < NOP) ? oprest : 4'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
        op       = '0;
    endtask

    // Called at the negedge right after the last pixel edge.
    task automatic wait_first(input string tag, input int exp_cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, cyc, exp_cyc);
    endtask

    task automatic collect(input int stall_at, input int stall_val, input logic exp_err);
        for (int i = 0; i < 16; i++) begin
            if (i == stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    check($sformatf("stall_data%0d", s), out_data, stall_val);
                    check($sformatf("stall_valid%0d", s), out_valid, 1);
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
            check($sformatf("beat_valid%0d", i), out_valid, 1);
`ifdef IDC_OPERR_EN
            check($sformatf("op_err%0d", i), op_err, exp_err);
`endif
            got[i] = out_data;
            @(negedge clk);
        end
        check("idle_valid", out_valid, 0);
        check("idle_data", out_data, 0);
`ifdef IDC_OPERR_EN
        check("idle_op_err", op_err, 0);
`endif
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        op        = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_valid", out_valid, 0);

        // All Left: window (3,0), zoom-in.
        send_frame(4'd6, 4'd6);
        wait_first("s1_latency", 16);
        collect(-1, 0, 1'b0);
        for (int i = 0; i < 16; i++) check($sformatf("s1_beat%0d", i), got[i], exp1[i]);

        // All Right: window (3,6), zoom-out.
        send_frame(4'd8, 4'd8);
        wait_first("s2_latency", 16);
        collect(-1, 0, 1'b0);
        for (int i = 0; i < 16; i++) check($sformatf("s2_beat%0d", i), got[i], exp2[i]);

        // Flip then Up: window (0,3), zoom-in from (1,4).
        send_frame(4'd4, 4'd5);
        wait_first("s3_latency", 16);
        collect(-1, 0, 1'b0);
        check("s3_beat0", got[0], -20);
        check("s3_beat8", got[8], 4);
        check("s3_beat9", got[9], -3);
        check("s3_beat12", got[12], -4);
        check("s3_beat13", got[13], 5);

        // Average of -5,-4,3,4 -> -2/4 -> 0.
        send_frame(4'd1, 4'd5);
        wait_first("s4a_latency", 16);
        collect(-1, 0, 1'b0);
        check("s4a_beat8", got[8], 0);
        check("s4a_beat12", got[12], 0);
        check("s4a_beat9", got[9], -3);

        // Midpoint: mid0=-4, mid1=3, -1/2 truncates to 0.
        send_frame(4'd0, 4'd5);
        wait_first("s4b_latency", 16);
        collect(-1, 0, 1'b0);
        check("s4b_beat8", got[8], 0);
        check("s4b_beat12", got[12], 0);
        check("s4b_beat13", got[13], 5);

        // CW: B<-A=-5, D<-B=-4.
        send_frame(4'd3, 4'd5);
        wait_first("cw_latency", 16);
        collect(-1, 0, 1'b0);
        check("cw_beat8", got[8], -5);
        check("cw_beat12", got[12], -4);

        // CCW: B<-D=4, D<-C=3.
        send_frame(4'd2, 4'd5);
        wait_first("ccw_latency", 16);
        collect(-1, 0, 1'b0);
        check("ccw_beat8", got[8], 4);
        check("ccw_beat12", got[12], 3);

        // Backpressure at beat 5 for 3 cycles.
        send_frame(4'd6, 4'd6);
        wait_first("s5_latency", 16);
        collect(5, 10, 1'b0);
        for (int i = 0; i < 16; i++) check($sformatf("s5_beat%0d", i), got[i], exp1[i]);

        // Reset mid-PROC aborts the frame.
        send_frame(4'd6, 4'd6);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_rst_valid", out_valid, 0);
        @(negedge clk);
        check("abort_rst_data", out_data, 0);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        check("abort_no_valid", seen, 0);
        send_frame(4'd8, 4'd8);
        wait_first("s6_latency", 16);
        collect(-1, 0, 1'b0);
        for (int i = 0; i < 16; i++) check($sformatf("s6_beat%0d", i), got[i], exp2[i]);

        // Illegal opcode 12 is a no-op; flags op_err when enabled.
        send_frame(4'd12, 4'd8);
        wait_first("err_latency", 16);
        collect(-1, 0, 1'b1);
        check("err_beat0", got[0], exp2[0]);
        check("err_beat15", got[15], exp2[15]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
